// File: rtl/if_id_decode.sv
// rtl/if_id_decode.sv - IF/ID pipeline register with field decode and a 32x32 register file.
// Register reads bypass a same-cycle writeback so decode always sees the newest value.
module if_id_decode #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        valid,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [31:0] imm_ext,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data
);

  logic [31:0] regs [32];
  logic        wb_write;

  assign wb_write = wb_en && (wb_addr != 5'd0);

  // Flush wins over stall; a flushed slot still tracks the incoming PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out    <= 32'h0;
      instr_out <= NOP_WORD;
      valid     <= 1'b0;
    end else if (flush) begin
      pc_out    <= pc_in;
      instr_out <= NOP_WORD;
      valid     <= 1'b0;
    end else if (!stall) begin
      pc_out    <= pc_in;
      instr_out <= instr_in;
      valid     <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0;
      end
    end else if (wb_write) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign opcode  = instr_out[31:26];
  assign rs      = instr_out[25:21];
  assign rt      = instr_out[20:16];
  assign rd      = instr_out[15:11];
  assign shamt   = instr_out[10:6];
  assign funct   = instr_out[5:0];
  assign imm_ext = {{16{instr_out[15]}}, instr_out[15:0]};

  assign rs_data = (rs == 5'd0) ? 32'h0 :
                   (wb_write && (wb_addr == rs)) ? wb_data : regs[rs];
  assign rt_data = (rt == 5'd0) ? 32'h0 :
                   (wb_write && (wb_addr == rt)) ? wb_data : regs[rt];

endmodule

// File: tb/tb_if_id_decode.sv
// tb/tb_if_id_decode.sv - directed and randomized checks of if_id_decode against a reference model.
module tb_if_id_decode;

  localparam logic [31:0] NOP = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, instr_in, wb_data;
  logic        stall, flush, wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] pc_out, instr_out, imm_ext, rs_data, rt_data;
  logic        valid;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_instr;
  logic        m_valid;
  logic [31:0] mregs [32];

  if_id_decode #(.NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in), .stall(stall),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .pc_out(pc_out), .instr_out(instr_out), .valid(valid), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm_ext(imm_ext), .rs_data(rs_data), .rt_data(rt_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input int idx);
    if (idx == 0) return 32'h0;
    if (wb_en && int'(wb_addr) == idx) return wb_data;
    return mregs[idx];
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_valid = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
  endtask

  task automatic model_edge();
    if (wb_en && wb_addr != 5'd0) mregs[wb_addr] = wb_data;
    if (flush) begin
      m_pc = pc_in; m_instr = NOP; m_valid = 1'b0;
    end else if (!stall) begin
      m_pc = pc_in; m_instr = instr_in; m_valid = 1'b1;
    end
  endtask

  task automatic check_reads(input string tag);
    chk({tag, ".rs_data"}, rs_data, exp_read(int'((m_instr >> 21) & 32'h1f)));
    chk({tag, ".rt_data"}, rt_data, exp_read(int'((m_instr >> 16) & 32'h1f)));
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc_out"}, pc_out, m_pc);
    chk({tag, ".instr_out"}, instr_out, m_instr);
    chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
    chk({tag, ".opcode"}, 32'(opcode), m_instr / 32'h0400_0000);
    chk({tag, ".rs"}, 32'(rs), (m_instr >> 21) % 32);
    chk({tag, ".rt"}, 32'(rt), (m_instr >> 16) % 32);
    chk({tag, ".rd"}, 32'(rd), (m_instr >> 11) % 32);
    chk({tag, ".shamt"}, 32'(shamt), (m_instr >> 6) % 32);
    chk({tag, ".funct"}, 32'(funct), m_instr % 64);
    chk({tag, ".imm_ext"}, imm_ext,
        (m_instr % 65536 >= 32768) ? (m_instr % 65536) + 32'hFFFF_0000 : m_instr % 65536);
    check_reads(tag);
  endtask

  // Called just after a rising edge; applies one edge and checks before and after it.
  task automatic cycle(input string tag);
    #1;
    check_reads({tag, ".pre"});
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; pc_in = 0; instr_in = 0; stall = 0; flush = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.pc_out", pc_out, 32'h0);
    chk("reset.instr_out", instr_out, NOP);
    chk("reset.valid", 32'(valid), 32'h0);

    rst = 1'b0; pc_in = 32'h4; instr_in = 32'h8C22_0010;
    cycle("load");
    chk("load.valid1", 32'(valid), 32'h1);
    chk("load.op23", 32'(opcode), 32'h23);
    chk("load.rs1", 32'(rs), 32'h1);
    chk("load.rt2", 32'(rt), 32'h2);
    chk("load.imm10", imm_ext, 32'h10);

    pc_in = 32'h8; instr_in = 32'h0043_0820;
    cycle("load2");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc_in = $urandom; instr_in = $urandom;
      cycle("stall");
      chk("stall.instr", instr_out, 32'h0043_0820);
      chk("stall.rd1", 32'(rd), 32'h1);
      chk("stall.funct20", 32'(funct), 32'h20);
      chk("stall.valid1", 32'(valid), 32'h1);
    end

    flush = 1'b1; pc_in = 32'h0000_1234;
    cycle("flush");
    chk("flush.instr", instr_out, NOP);
    chk("flush.valid0", 32'(valid), 32'h0);
    chk("flush.pc", pc_out, 32'h0000_1234);

    stall = 1'b0; flush = 1'b0; pc_in = 32'h10; instr_in = 32'h00A0_0000;
    cycle("load_rs5");
    stall = 1'b1; wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    #1;
    chk("bypass.before", rs_data, 32'hDEAD_BEEF);
    cycle("wb5");
    wb_en = 1'b0;
    #1;
    chk("bypass.after", rs_data, 32'hDEAD_BEEF);

    stall = 1'b0; pc_in = 32'h14; instr_in = 32'h0000_0000;
    cycle("load_r0");
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    #1;
    chk("r0.before", rs_data, 32'h0);
    cycle("r0");
    chk("r0.after", rs_data, 32'h0);

    wb_en = 1'b0; pc_in = 32'h40; instr_in = 32'h00A0_0000;
    cycle("load_pre_rst");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst.valid", 32'(valid), 32'h0);
    chk("arst.pc", pc_out, 32'h0);
    chk("arst.instr", instr_out, NOP);
    @(posedge clk);
    #1;
    rst = 1'b0; pc_in = 32'h44; instr_in = 32'h00A0_0000;
    cycle("post_rst");
    chk("arst.reg5", rs_data, 32'h0);

    for (int i = 0; i < 300; i++) begin
      pc_in = $urandom; instr_in = $urandom;
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      wb_en = ($urandom_range(0, 1) == 1);
      wb_addr = 5'($urandom_range(0, 31));
      wb_data = $urandom;
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_decode.md
IF_ID_DECODE -- requirements
Module: if_id_decode

Interface
REQ-001 Parameter NOP_WORD, default 32'h0000_0000, is the instruction word inserted on flush and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 pc_in  input  32  address of the fetched instruction from the fetch stage.
REQ-005 instr_in  input  32  fetched instruction word, big-endian concatenation of four memory bytes.
REQ-006 stall  input  1  hold the IF/ID register contents.
REQ-007 flush  input  1  replace the IF/ID contents with a bubble.
REQ-008 wb_en  input  1  register-file write enable from writeback.
REQ-009 wb_addr  input  5  register-file write index.
REQ-010 wb_data  input  32  register-file write data.
REQ-011 pc_out  output  32  latched PC.
REQ-012 instr_out  output  32  latched instruction.
REQ-013 valid  output  1  the latched instruction is real, not a bubble.
REQ-014 opcode  output  6, rs  output  5, rt  output  5, rd  output  5, shamt  output  5, funct  output  6: fields of instr_out at bits [31:26], [25:21], [20:16], [15:11], [10:6] and [5:0].
REQ-015 imm_ext  output  32  instr_out[15:0] sign-extended.
REQ-016 rs_data  output  32, rt_data  output  32: register-file read data for rs and rt.

Function
REQ-017 On each rising clk edge with rst low, the IF/ID register updates according to the priority order flush > stall > load.
REQ-018 Flush: instr_out <= NOP_WORD, pc_out <= pc_in, valid <= 0.
REQ-019 Stall without flush: pc_out, instr_out and valid hold their values.
REQ-020 Load: pc_out <= pc_in, instr_out <= instr_in, valid <= 1. The latency from fetch to decode outputs is exactly one cycle.
REQ-021 The field outputs and imm_ext are combinational from instr_out and change only when the IF/ID register changes.
REQ-022 The register file holds 32 entries of 32 bits.
- It writes wb_data to entry wb_addr on the rising clk edge when wb_en=1 and wb_addr!=0.
- Writes to index 0 are discarded.
REQ-023 Register 0 reads as 32'h0 at all times.
REQ-024 Reads are combinational on rs and rt, with write-through bypass.
- If wb_en=1, wb_addr!=0 and wb_addr equals the read index, the read returns wb_data in the same cycle.
REQ-025 Writeback is independent of stall and flush; register-file writes proceed during both.
REQ-026 When stall and flush are asserted in the same cycle, flush takes effect.
REQ-027 A stall lasting N cycles keeps all outputs except rs_data and rt_data constant for N cycles. rs_data and rt_data may change through writeback.
REQ-028 pc_in wraps as delivered; the block performs no arithmetic on the PC.

Reset
REQ-029 While rst=1, independent of clk:
- pc_out = 0, instr_out = NOP_WORD, valid = 0.
- All 32 register-file entries = 0.
REQ-030 Deassertion of rst takes effect at the next rising clk edge. The first edge with rst low performs a normal flush/stall/load update.
REQ-031 Asserting rst mid-stall or mid-flush overrides both immediately and asynchronously.

Verification
REQ-032 Reset then load: rst pulse, then pc_in=0x4 and instr_in=0x8C220010 with no stall or flush, one edge.
- Required response: valid=1, opcode=0x23, rs=1, rt=2, imm_ext=0x00000010.
REQ-033 Stall: load 0x00430820 at pc 0x8, then stall=1 for 3 edges while instr_in changes each cycle.
- Required response: instr_out stays 0x00430820, rd=1, funct=0x20, valid=1.
REQ-034 Flush with simultaneous stall: stall=1 and flush=1 on the same edge.
- Required response: instr_out=NOP_WORD, valid=0, pc_out=pc_in.
REQ-035 Writeback and bypass:
- wb_en=1, wb_addr=5, wb_data=0xDEADBEEF while instr_out has rs=5. Required response: rs_data=0xDEADBEEF combinationally, before the edge.
- After the edge, rs_data=0xDEADBEEF with wb_en=0.
REQ-036 Register 0 protection: write wb_addr=0, wb_data=0xFFFFFFFF.
- Required response: a read of register 0 returns 0 before and after the edge.
REQ-037 Asynchronous reset mid-operation: assert rst between clock edges after loading data.
- Required response: valid, pc_out and register-file reads go to 0 immediately.
